debug_ctrl: RTL and testbench

DEBUG_CTRL -- requirements
Module: debug_ctrl

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/debug_ctrl_bp_table.sv | 60 ++++++
 rtl/debug_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_debug_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared debug-controller types: command/response codes, halt causes, FSM states
// and the architectural PC width.
package cpu_pkg;

    localparam int unsigned PC_W = 16;

    typedef enum logic [2:0] {
        CMD_HALT   = 3'd0,
        CMD_RESUME = 3'd1,
        CMD_STEP   = 3'd2,
        CMD_SET_BP = 3'd3,
        CMD_CLR_BP = 3'd4
    } dbg_cmd_e;

    typedef enum logic {
        RSP_OK  = 1'b0,
        RSP_ERR = 1'b1
    } dbg_rsp_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_REQ  = 2'd1,
        CAUSE_BP   = 2'd2,
        CAUSE_STEP = 2'd3
    } halt_cause_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STEP   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } dbg_state_e;

endpackage

// File: rtl/debug_ctrl_bp_table.sv
// PC breakpoint slots: commit-PC match, lowest-free-slot allocation and
// clear-by-value of every matching valid slot.
module bp_table
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_BP = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic            clr_en,
    input  logic [PC_W-1:0] wr_pc,
    input  logic [PC_W-1:0] cmp_pc,
    output logic            match,
    output logic            has_free,
    output logic            clr_hit
);

    logic [PC_W-1:0]   slot_pc [NUM_BP];
    logic [NUM_BP-1:0] slot_vld;
    logic [NUM_BP-1:0] free_sel;
    logic [NUM_BP-1:0] eq_cmp;
    logic [NUM_BP-1:0] eq_wr;

    always_comb begin
        free_sel = '0;
        has_free = 1'b0;
        eq_cmp   = '0;
        eq_wr    = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (!slot_vld[i] && !has_free) begin
                free_sel[i] = 1'b1;
                has_free    = 1'b1;
            end
            eq_cmp[i] = slot_vld[i] && (slot_pc[i] == cmp_pc);
            eq_wr[i]  = slot_vld[i] && (slot_pc[i] == wr_pc);
        end
        match   = |eq_cmp;
        clr_hit = |eq_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                slot_pc[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                if (set_en && free_sel[i]) begin
                    slot_vld[i] <= 1'b1;
                    slot_pc[i]  <= wr_pc;
                end else if (clr_en && eq_wr[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/debug_ctrl.sv
// Run-control debug block: halt/resume/step the CPU, PC breakpoints, and a
// single-outstanding request/response command channel.
module debug_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_BP        = 2,
    parameter bit          HALT_ON_RESET = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_cmd,
    input  logic [PC_W-1:0] req_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_code,
    input  logic            commit_valid,
    input  logic [PC_W-1:0] commit_pc,
    input  logic            cpu_quiesced,
    output logic            run_en,
    output logic            halted,
    output logic [1:0]      halt_cause
);

    dbg_state_e      state_q, state_n;
    halt_cause_e     cause_q, cause_n;
    dbg_rsp_e        rsp_code_q, rsp_code_n;
    logic [PC_W-1:0] cnt_q, cnt_n;
    logic            sup_q, sup_n;
    logic            pend_q, pend_n;
    logic            rsp_valid_q, rsp_valid_n;
    logic            run_en_q, halted_q;

    logic            set_en, clr_en;
    logic            bp_match, has_free, clr_hit;
    logic            accept, running, hit;

    bp_table #(.NUM_BP(NUM_BP)) u_bp_table (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .clr_en   (clr_en),
        .wr_pc    (req_data),
        .cmp_pc   (commit_pc),
        .match    (bp_match),
        .has_free (has_free),
        .clr_hit  (clr_hit)
    );

    assign req_ready = !rsp_valid_q && (state_q != ST_DRAIN);
    assign accept    = req_valid && req_ready;
    assign running   = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign hit       = running && commit_valid && bp_match && !sup_q;

    always_comb begin
        state_n     = state_q;
        cause_n     = cause_q;
        cnt_n       = cnt_q;
        sup_n       = sup_q;
        pend_n      = pend_q;
        rsp_valid_n = rsp_valid_q && !rsp_ready;
        rsp_code_n  = rsp_code_q;
        set_en      = 1'b0;
        clr_en      = 1'b0;

        if (running && commit_valid) begin
            sup_n = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (hit) begin
                    state_n = ST_DRAIN;
                    cause_n = CAUSE_BP;
                end
            end
            ST_STEP: begin
                if (commit_valid) begin
                    cnt_n = cnt_q - 16'd1;
                    if (hit) begin
                        state_n = ST_DRAIN;
                        cause_n = CAUSE_BP;
                    end else if (cnt_q == 16'd1) begin
                        state_n = ST_DRAIN;
                        cause_n = CAUSE_STEP;
                    end
                end
            end
            ST_DRAIN: begin
                // A HALT accepted while running is answered only once halted.
                if (cpu_quiesced) begin
                    state_n = ST_HALTED;
                    if (pend_q) begin
                        rsp_valid_n = 1'b1;
                        rsp_code_n  = RSP_OK;
                        pend_n      = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        if (accept) begin
            rsp_valid_n = 1'b1;
            rsp_code_n  = RSP_ERR;
            case (dbg_cmd_e'(req_cmd))
                CMD_HALT: begin
                    if (state_q == ST_HALTED) begin
                        rsp_code_n = RSP_OK;
                    end else begin
                        rsp_valid_n = 1'b0;
                        pend_n      = 1'b1;
                        state_n     = ST_DRAIN;
                        if (!hit) begin
                            cause_n = CAUSE_REQ;
                        end
                    end
                end
                CMD_RESUME: begin
                    if (state_q == ST_HALTED) begin
                        state_n    = ST_RUN;
                        cause_n    = CAUSE_NONE;
                        sup_n      = 1'b1;
                        rsp_code_n = RSP_OK;
                    end
                end
                CMD_STEP: begin
                    if ((state_q == ST_HALTED) && (req_data != '0)) begin
                        state_n    = ST_STEP;
                        cause_n    = CAUSE_NONE;
                        cnt_n      = req_data;
                        sup_n      = 1'b1;
                        rsp_code_n = RSP_OK;
                    end
                end
                CMD_SET_BP: begin
                    if (has_free) begin
                        set_en     = 1'b1;
                        rsp_code_n = RSP_OK;
                    end
                end
                CMD_CLR_BP: begin
                    if (clr_hit) begin
                        clr_en     = 1'b1;
                        rsp_code_n = RSP_OK;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HALT_ON_RESET ? ST_HALTED : ST_RUN;
            cause_q     <= CAUSE_NONE;
            cnt_q       <= '0;
            sup_q       <= 1'b1;
            pend_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= RSP_OK;
            run_en_q    <= !HALT_ON_RESET;
            halted_q    <= HALT_ON_RESET;
        end else begin
            state_q     <= state_n;
            cause_q     <= cause_n;
            cnt_q       <= cnt_n;
            sup_q       <= sup_n;
            pend_q      <= pend_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_code_q  <= rsp_code_n;
            run_en_q    <= (state_n == ST_RUN) || (state_n == ST_STEP);
            halted_q    <= (state_n == ST_HALTED);
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_code   = rsp_code_q;
    assign run_en     = run_en_q;
    assign halted     = halted_q;
    assign halt_cause = cause_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Directed bench for debug_ctrl; u_dut0 leaves reset running, u_dut1 leaves
// reset halted, both share stimulus.
module tb_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_cmd = 3'd0;
    logic [15:0] req_data = 16'd0;
    logic        rsp_ready = 1'b1;
    logic        commit_valid = 1'b0;
    logic [15:0] commit_pc = 16'd0;
    logic        cpu_quiesced = 1'b0;

    logic        req_ready0, rsp_valid0, rsp_code0, run_en0, halted0;
    logic [1:0]  cause0;
    logic        req_ready1, rsp_valid1, rsp_code1, run_en1, halted1;
    logic [1:0]  cause1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    debug_ctrl #(.NUM_BP(2), .HALT_ON_RESET(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
        .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid0),
        .rsp_ready(rsp_ready), .rsp_code(rsp_code0), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .cpu_quiesced(cpu_quiesced), .run_en(run_en0),
        .halted(halted0), .halt_cause(cause0)
    );

    debug_ctrl #(.NUM_BP(2), .HALT_ON_RESET(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid1),
        .rsp_ready(rsp_ready), .rsp_code(rsp_code1), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .cpu_quiesced(cpu_quiesced), .run_en(run_en1),
        .halted(halted1), .halt_cause(cause1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] cmd, input logic [15:0] data);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_data  = data;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        total++; if (run_en0 !== 1'b1) begin bad++; $display("FAIL rst0_run_en: got %b want 1", run_en0); end
        total++; if (halted0 !== 1'b0) begin bad++; $display("FAIL rst0_halted: got %b want 0", halted0); end
        total++; if (cause0 !== 2'd0) begin bad++; $display("FAIL rst0_cause: got %0d want 0", cause0); end
        total++; if (rsp_valid0 !== 1'b0 || rsp_code0 !== 1'b0) begin bad++; $display("FAIL rst0_rsp: got v=%b c=%b want v=0 c=0", rsp_valid0, rsp_code0); end
        total++; if (run_en1 !== 1'b0 || halted1 !== 1'b1) begin bad++; $display("FAIL rst1_state: got run_en=%b halted=%b want 0/1", run_en1, halted1); end
        rst = 1'b0;
        tick();
        total++; if (req_ready0 !== 1'b1) begin bad++; $display("FAIL rst0_req_ready: got %b want 1", req_ready0); end
    endtask

    task automatic test_halt();
        send(3'd0, 16'd0);
        total++; if (run_en0 !== 1'b0) begin bad++; $display("FAIL halt_run_en: got %b want 0", run_en0); end
        total++; if (req_ready0 !== 1'b0 || rsp_valid0 !== 1'b0) begin bad++; $display("FAIL halt_drain_io: got rdy=%b v=%b want 0/0", req_ready0, rsp_valid0); end
        tick();
        tick();
        tick();
        total++; if (halted0 !== 1'b0) begin bad++; $display("FAIL halt_early: got %b want 0", halted0); end
        cpu_quiesced = 1'b1;
        tick();
        cpu_quiesced = 1'b0;
        total++; if (halted0 !== 1'b1) begin bad++; $display("FAIL halt_halted: got %b want 1", halted0); end
        total++; if (rsp_valid0 !== 1'b1 || rsp_code0 !== 1'b0) begin bad++; $display("FAIL halt_rsp: got v=%b c=%b want 1/0", rsp_valid0, rsp_code0); end
        total++; if (cause0 !== 2'd1) begin bad++; $display("FAIL halt_cause: got %0d want 1", cause0); end
        tick();
        total++; if (rsp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin bad++; $display("FAIL halt_consume: got v=%b rdy=%b want 0/1", rsp_valid0, req_ready0); end
        send(3'd0, 16'd0);
        total++; if (rsp_valid0 !== 1'b1 || rsp_code0 !== 1'b0 || cause0 !== 2'd1) begin bad++; $display("FAIL halt_in_halted: got v=%b c=%b cause=%0d want 1/0/1", rsp_valid0, rsp_code0, cause0); end
        tick();
    endtask

    task automatic test_bp();
        send(3'd3, 16'h0040);
        total++; if (rsp_valid0 !== 1'b1 || rsp_code0 !== 1'b0) begin bad++; $display("FAIL bp_set: got v=%b c=%b want 1/0", rsp_valid0, rsp_code0); end
        tick();
        send(3'd1, 16'd0);
        total++; if (run_en0 !== 1'b1 || cause0 !== 2'd0 || rsp_code0 !== 1'b0) begin bad++; $display("FAIL bp_resume: got run_en=%b cause=%0d c=%b want 1/0/0", run_en0, cause0, rsp_code0); end
        tick();
        commit_valid = 1'b1; commit_pc = 16'h003C;
        tick();
        commit_pc = 16'h0040;
        tick();
        commit_valid = 1'b0;
        total++; if (run_en0 !== 1'b0 || req_ready0 !== 1'b0) begin bad++; $display("FAIL bp_drain: got run_en=%b rdy=%b want 0/0", run_en0, req_ready0); end
        cpu_quiesced = 1'b1;
        tick();
        cpu_quiesced = 1'b0;
        total++; if (halted0 !== 1'b1 || cause0 !== 2'd2) begin bad++; $display("FAIL bp_halted: got halted=%b cause=%0d want 1/2", halted0, cause0); end
        total++; if (rsp_valid0 !== 1'b0) begin bad++; $display("FAIL bp_no_rsp: got %b want 0", rsp_valid0); end
        tick();
        send(3'd1, 16'd0);
        tick();
        commit_valid = 1'b1; commit_pc = 16'h0040;
        tick();
        commit_valid = 1'b0;
        total++; if (run_en0 !== 1'b1 || halted0 !== 1'b0) begin bad++; $display("FAIL bp_suppress: got run_en=%b halted=%b want 1/0", run_en0, halted0); end
        send(3'd1, 16'd0);
        total++; if (rsp_valid0 !== 1'b1 || rsp_code0 !== 1'b1) begin bad++; $display("FAIL resume_in_run: got v=%b c=%b want 1/1", rsp_valid0, rsp_code0); end
        tick();
        send(3'd2, 16'd5);
        total++; if (rsp_code0 !== 1'b1 || run_en0 !== 1'b1) begin bad++; $display("FAIL step_in_run: got c=%b run_en=%b want 1/1", rsp_code0, run_en0); end
        tick();
        send(3'd0, 16'd0);
        cpu_quiesced = 1'b1;
        tick();
        cpu_quiesced = 1'b0;
        tick();
        send(3'd4, 16'h0040);
        total++; if (rsp_code0 !== 1'b0) begin bad++; $display("FAIL bp_clr: got c=%b want 0", rsp_code0); end
        tick();
    endtask

    task automatic test_step();
        send(3'd2, 16'd3);
        total++; if (rsp_valid0 !== 1'b1 || rsp_code0 !== 1'b0 || run_en0 !== 1'b1) begin bad++; $display("FAIL step_start: got v=%b c=%b run_en=%b want 1/0/1", rsp_valid0, rsp_code0, run_en0); end
        tick();
        for (int i = 0; i < 3; i++) begin
            commit_valid = 1'b1;
            commit_pc = 16'h0100 + 16'(i * 4);
            tick();
            commit_valid = 1'b0;
            total++; if (run_en0 !== (i < 2)) begin bad++; $display("FAIL step_commit%0d: got run_en=%b want %b", i, run_en0, (i < 2)); end
            tick();
        end
        cpu_quiesced = 1'b1;
        tick();
        cpu_quiesced = 1'b0;
        total++; if (halted0 !== 1'b1 || cause0 !== 2'd3) begin bad++; $display("FAIL step_halted: got halted=%b cause=%0d want 1/3", halted0, cause0); end
        tick();
    endtask

    task automatic test_errors();
        send(3'd3, 16'h0010);
        total++; if (rsp_code0 !== 1'b0) begin bad++; $display("FAIL err_set1: got %b want 0", rsp_code0); end
        tick();
        send(3'd3, 16'h0020);
        total++; if (rsp_code0 !== 1'b0) begin bad++; $display("FAIL err_set2: got %b want 0", rsp_code0); end
        tick();
        send(3'd3, 16'h0030);
        total++; if (rsp_valid0 !== 1'b1 || rsp_code0 !== 1'b1) begin bad++; $display("FAIL err_set3: got v=%b c=%b want 1/1", rsp_valid0, rsp_code0); end
        tick();
        send(3'd4, 16'h1234);
        total++; if (rsp_code0 !== 1'b1) begin bad++; $display("FAIL err_clr_absent: got %b want 1", rsp_code0); end
        tick();
        send(3'd2, 16'd0);
        total++; if (rsp_code0 !== 1'b1 || halted0 !== 1'b1) begin bad++; $display("FAIL err_step0: got c=%b halted=%b want 1/1", rsp_code0, halted0); end
        tick();
        send(3'd6, 16'd0);
        total++; if (rsp_code0 !== 1'b1 || halted0 !== 1'b1) begin bad++; $display("FAIL err_illegal: got c=%b halted=%b want 1/1", rsp_code0, halted0); end
        tick();
        send(3'd4, 16'h0010);
        tick();
        send(3'd4, 16'h0020);
        total++; if (rsp_code0 !== 1'b0) begin bad++; $display("FAIL err_clr2: got %b want 0", rsp_code0); end
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        send(3'd7, 16'd0);
        for (int i = 0; i < 5; i++) begin
            total++; if (rsp_valid0 !== 1'b1 || rsp_code0 !== 1'b1 || req_ready0 !== 1'b0) begin bad++; $display("FAIL bp_hold%0d: got v=%b c=%b rdy=%b want 1/1/0", i, rsp_valid0, rsp_code0, req_ready0); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        total++; if (rsp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin bad++; $display("FAIL hold_release: got v=%b rdy=%b want 0/1", rsp_valid0, req_ready0); end
    endtask

    task automatic test_step_bp();
        send(3'd3, 16'h0304);
        tick();
        send(3'd2, 16'd2);
        tick();
        commit_valid = 1'b1; commit_pc = 16'h0300;
        tick();
        commit_pc = 16'h0304;
        tick();
        commit_valid = 1'b0;
        total++; if (run_en0 !== 1'b0) begin bad++; $display("FAIL stepbp_drain: got run_en=%b want 0", run_en0); end
        cpu_quiesced = 1'b1;
        tick();
        cpu_quiesced = 1'b0;
        total++; if (halted0 !== 1'b1 || cause0 !== 2'd2) begin bad++; $display("FAIL stepbp_cause: got halted=%b cause=%0d want 1/2", halted0, cause0); end
        send(3'd4, 16'h0304);
        tick();
    endtask

    task automatic test_halt_hit();
        send(3'd3, 16'h0200);
        tick();
        send(3'd1, 16'd0);
        tick();
        commit_valid = 1'b1; commit_pc = 16'h01FC;
        tick();
        commit_pc = 16'h0200;
        send(3'd0, 16'd0);
        commit_valid = 1'b0;
        total++; if (run_en0 !== 1'b0 || rsp_valid0 !== 1'b0) begin bad++; $display("FAIL hh_drain: got run_en=%b v=%b want 0/0", run_en0, rsp_valid0); end
        cpu_quiesced = 1'b1;
        tick();
        cpu_quiesced = 1'b0;
        total++; if (halted0 !== 1'b1 || cause0 !== 2'd2) begin bad++; $display("FAIL hh_cause: got halted=%b cause=%0d want 1/2", halted0, cause0); end
        total++; if (rsp_valid0 !== 1'b1 || rsp_code0 !== 1'b0) begin bad++; $display("FAIL hh_rsp: got v=%b c=%b want 1/0", rsp_valid0, rsp_code0); end
        tick();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send(3'd3, 16'h0055);
        tick();
        send(3'd1, 16'd0);
        total++; if (rsp_code0 !== 1'b1 || rsp_code1 !== 1'b0 || run_en1 !== 1'b1) begin bad++; $display("FAIL rm_resume: got c0=%b c1=%b run_en1=%b want 1/0/1", rsp_code0, rsp_code1, run_en1); end
        tick();
        send(3'd0, 16'd0);
        total++; if (run_en0 !== 1'b0 || run_en1 !== 1'b0) begin bad++; $display("FAIL rm_drain: got run_en0=%b run_en1=%b want 0/0", run_en0, run_en1); end
        tick();
        rst = 1'b1;
        #2;
        total++; if (run_en0 !== 1'b1 || halted0 !== 1'b0 || cause0 !== 2'd0 || rsp_valid0 !== 1'b0 || rsp_code0 !== 1'b0) begin bad++; $display("FAIL rm_rst0: got run_en=%b halted=%b cause=%0d v=%b c=%b want 1/0/0/0/0", run_en0, halted0, cause0, rsp_valid0, rsp_code0); end
        total++; if (run_en1 !== 1'b0 || halted1 !== 1'b1 || cause1 !== 2'd0 || rsp_valid1 !== 1'b0 || rsp_code1 !== 1'b0) begin bad++; $display("FAIL rm_rst1: got run_en=%b halted=%b cause=%0d v=%b c=%b want 0/1/0/0/0", run_en1, halted1, cause1, rsp_valid1, rsp_code1); end
        tick();
        rst = 1'b0;
        cpu_quiesced = 1'b1;
        tick();
        cpu_quiesced = 1'b0;
        total++; if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin bad++; $display("FAIL rm_rsp_discard: got v0=%b v1=%b want 0/0", rsp_valid0, rsp_valid1); end
        send(3'd4, 16'h0055);
        total++; if (rsp_code0 !== 1'b1 || rsp_code1 !== 1'b1) begin bad++; $display("FAIL rm_slots_cleared: got c0=%b c1=%b want 1/1", rsp_code0, rsp_code1); end
        tick();
    endtask

    initial begin
        test_reset();
        test_halt();
        test_bp();
        test_step();
        test_errors();
        test_backpressure();
        test_step_bp();
        test_halt_hit();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
